// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory access unit: size codes, fault codes
// and FSM states, plus the alignment rule used when a request is accepted.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE    = 2'd0;
  localparam logic [1:0] SZ_HALF    = 2'd1;
  localparam logic [1:0] SZ_WORD    = 2'd2;
  localparam logic [1:0] SZ_ILLEGAL = 2'd3;

  localparam logic [1:0] FLT_NONE     = 2'd0;
  localparam logic [1:0] FLT_MISALIGN = 2'd1;
  localparam logic [1:0] FLT_TIMEOUT  = 2'd2;
  localparam logic [1:0] FLT_ILLEGAL  = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    return ((size == SZ_HALF) && off[0]) || ((size == SZ_WORD) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane logic: byte enables, store replication and load
// extract/extend for a little-endian 32-bit data bus.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b    = rdata[{offset, 3'b000} +: 8];
    lane_h    = offset[1] ? rdata[31:16] : rdata[15:0];
    be        = '0;
    wdata_rep = wdata;
    rdata_ext = rdata;
    case (size)
      SZ_BYTE: begin
        be        = 4'b0001 << offset;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{sign_ext & lane_b[7]}}, lane_b};
      end
      SZ_HALF: begin
        be        = offset[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {{16{sign_ext & lane_h[15]}}, lane_h};
      end
      SZ_WORD: begin
        be        = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = rdata;
      end
      default: begin
        be        = '0;
        wdata_rep = wdata;
        rdata_ext = rdata;
      end
    endcase
  end

endmodule

// File: rtl/dmem_access_unit.sv
// Load/store stage: latches a request, runs a handshaked memory access with
// a wait-state timeout, and returns aligned/extended load data on DY.
module dmem_access_unit
  import dmem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        start,
  input  logic        rd,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] ADDR,
  input  logic [31:0] WDATA,
  output logic [31:0] DY,
  output logic        busy,
  output logic        done,
  output logic [1:0]  fault,
  output logic        mem_cs,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  fault_q, fault_d;
  logic [31:0] addr_q, wdata_q, dy_q;
  logic [1:0]  size_q;
  logic        sext_q, rd_q, wr_q;
  logic        accept, dy_load;
  logic [3:0]  be_w;
  logic [31:0] wrep_w, rext_w;

  dmem_lane_align u_lane (
    .size      (size_q),
    .offset    (addr_q[1:0]),
    .sign_ext  (sext_q),
    .wdata     (wdata_q),
    .rdata     (mem_rdata),
    .be        (be_w),
    .wdata_rep (wrep_w),
    .rdata_ext (rext_w)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fault_q <= FLT_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  // Fault classification happens on the live inputs so a bad request goes
  // straight to DONE without ever strobing memory.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;
    accept  = 1'b0;
    dy_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept = 1'b1;
          cnt_d  = '0;
          if ((rd == wr) || (size == SZ_ILLEGAL)) begin
            state_d = DONE;
            fault_d = FLT_ILLEGAL;
          end else if (is_misaligned(size, ADDR[1:0])) begin
            state_d = DONE;
            fault_d = FLT_MISALIGN;
          end else begin
            state_d = ACCESS;
            fault_d = FLT_NONE;
          end
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          state_d = DONE;
          fault_d = FLT_NONE;
          dy_load = rd_q;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if ((cnt_q + 8'd1) == 8'(TIMEOUT)) begin
            state_d = DONE;
            fault_d = FLT_TIMEOUT;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= SZ_BYTE;
      sext_q  <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      dy_q    <= '0;
    end else begin
      if (accept) begin
        addr_q  <= ADDR;
        wdata_q <= WDATA;
        size_q  <= size;
        sext_q  <= sign_ext;
        rd_q    <= rd;
        wr_q    <= wr;
      end
      if (dy_load) begin
        dy_q <= rext_w;
      end
    end
  end

  always_comb begin
    DY        = dy_q;
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    fault     = fault_q;
    mem_cs    = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_be    = '0;
    mem_wdata = '0;
    if (state_q == ACCESS) begin
      mem_cs    = 1'b1;
      mem_rd    = rd_q;
      mem_wr    = wr_q;
      mem_addr  = {addr_q[31:2], 2'b00};
      mem_be    = be_w;
      mem_wdata = wrep_w;
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Self-checking bench for dmem_access_unit: directed cases plus randomized
// accesses compared against an arithmetic reference model.
module tb_dmem_access_unit;

  localparam int T = 4;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        start, rd, wr, sign_ext, mem_ack;
  logic [1:0]  size;
  logic [31:0] ADDR, WDATA, mem_rdata;
  logic [31:0] DY, mem_addr, mem_wdata;
  logic        busy, done, mem_cs, mem_rd, mem_wr;
  logic [1:0]  fault;
  logic [3:0]  mem_be;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] dy_model = '0;

  dmem_access_unit #(.TIMEOUT(T)) dut (
    .CLK(CLK), .RESET(RESET), .start(start), .rd(rd), .wr(wr), .size(size),
    .sign_ext(sign_ext), .ADDR(ADDR), .WDATA(WDATA), .DY(DY), .busy(busy),
    .done(done), .fault(fault), .mem_cs(mem_cs), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scramble request inputs while the unit is busy; it must ignore them.
  task automatic noise();
    start    = 1'($urandom_range(0, 1));
    rd       = 1'($urandom_range(0, 1));
    wr       = 1'($urandom_range(0, 1));
    size     = 2'($urandom_range(0, 3));
    sign_ext = 1'($urandom_range(0, 1));
    ADDR     = $urandom;
    WDATA    = $urandom;
  endtask

  // Entered and left at a negedge with the unit idle.
  task automatic access(input logic r, input logic w, input logic [1:0] sz,
                        input logic sx, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rdat, input int wait_n);
    logic [1:0]  ef;
    logic [31:0] ebe, ewd, lane, v;
    int          n;
    int          off;
    off = int'(a[1:0]);
    if (r == w || sz == 2'd3)                               ef = 2'd3;
    else if ((sz == 2'd1 && a[0]) || (sz == 2'd2 && off != 0)) ef = 2'd1;
    else if (wait_n >= T)                                   ef = 2'd2;
    else                                                    ef = 2'd0;
    case (sz)
      2'd0:    begin ebe = 32'd1 << off; ewd = 32'(wd[7:0]) * 32'h0101_0101; end
      2'd1:    begin ebe = 32'd3 << off; ewd = 32'(wd[15:0]) * 32'h0001_0001; end
      default: begin ebe = 32'd15;       ewd = wd; end
    endcase
    lane = rdat >> (8 * off);
    case (sz)
      2'd0:    begin v = lane & 32'hFF;   if (sx && v >= 32'd128)   v = v | 32'hFFFF_FF00; end
      2'd1:    begin v = lane & 32'hFFFF; if (sx && v >= 32'd32768) v = v | 32'hFFFF_0000; end
      default: v = rdat;
    endcase
    if (ef == 2'd1 || ef == 2'd3) n = 0;
    else if (ef == 2'd2)          n = T;
    else                          n = wait_n + 1;

    start = 1'b1; rd = r; wr = w; size = sz; sign_ext = sx; ADDR = a; WDATA = wd;
    mem_ack = 1'b0;
    @(posedge CLK);
    for (int c = 1; c <= n; c++) begin
      @(negedge CLK);
      chk("mem_cs",    32'(mem_cs), 32'd1);
      chk("mem_rd",    32'(mem_rd), 32'(r));
      chk("mem_wr",    32'(mem_wr), 32'(w));
      chk("mem_addr",  mem_addr, {a[31:2], 2'b00});
      chk("mem_be",    32'(mem_be), ebe);
      chk("mem_wdata", mem_wdata, ewd);
      chk("done_early", 32'(done), 32'd0);
      chk("busy",      32'(busy), 32'd1);
      noise();
      mem_ack   = (c == n && ef == 2'd0);
      mem_rdata = (c == n && ef == 2'd0) ? rdat : $urandom;
    end
    @(negedge CLK);
    chk("done",      32'(done), 32'd1);
    chk("fault",     32'(fault), 32'(ef));
    chk("cs_in_done", 32'(mem_cs), 32'd0);
    chk("be_in_done", 32'(mem_be), 32'd0);
    chk("busy_done", 32'(busy), 32'd1);
    if (ef == 2'd0 && r) dy_model = v;
    chk("DY",        DY, dy_model);
    noise();
    mem_ack   = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    @(negedge CLK);
    chk("done_clear", 32'(done), 32'd0);
    chk("busy_clear", 32'(busy), 32'd0);
    chk("cs_idle",    32'(mem_cs), 32'd0);
    chk("DY_hold",    DY, dy_model);
    start = 1'b0; mem_ack = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; start = 1'b0; rd = 1'b0; wr = 1'b0; size = '0; sign_ext = 1'b0;
    ADDR = '0; WDATA = '0; mem_rdata = '0; mem_ack = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_DY", DY, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_cs", 32'(mem_cs), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    RESET = 1'b0;
    @(negedge CLK);

    access(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0104, $urandom, 32'hDEAD_BEEF, 0);
    access(1'b1, 1'b0, 2'd0, 1'b1, 32'h0000_0203, $urandom, 32'h8012_3456, 0);
    access(1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_0203, $urandom, 32'h8012_3456, 1);
    access(1'b0, 1'b1, 2'd1, 1'b0, 32'h0000_0002, 32'h1234_ABCD, $urandom, 3);
    access(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0001, $urandom, $urandom, 0);
    access(1'b1, 1'b1, 2'd2, 1'b0, 32'h0000_0000, $urandom, $urandom, 0);
    access(1'b0, 1'b0, 2'd0, 1'b0, 32'h0000_0000, $urandom, $urandom, 0);
    access(1'b1, 1'b0, 2'd3, 1'b0, 32'h0000_0000, $urandom, $urandom, 0);
    access(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0040, $urandom, $urandom, T);
    access(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0040, $urandom, 32'h0BAD_F00D, T - 1);
    access(1'b1, 1'b0, 2'd1, 1'b1, 32'h0000_0012, $urandom, 32'hF00F_1234, 2);

    for (int i = 0; i < 150; i++) begin
      access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, $urandom_range(0, T + 1));
    end

    // Asynchronous reset in the middle of a waiting access.
    start = 1'b1; rd = 1'b1; wr = 1'b0; size = 2'd2; ADDR = 32'h0000_0100; mem_ack = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    start = 1'b0;
    chk("pre_rst_cs", 32'(mem_cs), 32'd1);
    @(negedge CLK);
    #1 RESET = 1'b1;
    #1;
    chk("arst_cs", 32'(mem_cs), 32'd0);
    chk("arst_rd", 32'(mem_rd), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_DY", DY, 32'd0);
    chk("arst_be", 32'(mem_be), 32'd0);
    chk("arst_addr", mem_addr, 32'd0);
    dy_model = '0;
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    chk("post_rst_done", 32'(done), 32'd0);
    access(1'b1, 1'b0, 2'd1, 1'b1, 32'h0000_0302, $urandom, 32'h9ABC_0000, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
